// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide RAM with async read, sync write.
// Optional LSU_ALIGN_CHECK_EN adds an error path for misaligned or reserved-size requests.
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
`ifdef LSU_ALIGN_CHECK_EN
    S_ERR,
`endif
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;   // also serves as the read-modify-write merge register
  logic [31:0]        rdata_q, rdata_d;
  logic [15:0]        sdata_q, sdata_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic               sgn_q, sgn_d;

  logic [1:0]         req_size_n;
  logic [1:0]         req_off_n;

`ifdef LSU_ALIGN_CHECK_EN
  logic req_bad;
  assign req_size_n = req_size;
  assign req_off_n  = req_addr[1:0];
  assign req_bad    = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  // Without the check, size 11 acts as word and low address bits are masked to alignment.
  assign req_size_n = (req_size == 2'b11) ? 2'b10 : req_size;
  always_comb begin
    case (req_size_n)
      2'b00:   req_off_n = req_addr[1:0];
      2'b01:   req_off_n = {req_addr[1], 1'b0};
      default: req_off_n = 2'b00;
    endcase
  end
`endif

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8]     = d[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = d;
      default: m = w;
    endcase
    return m;
  endfunction

  always_comb begin
    // NOTE: every _d gets its current value first so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sdata_d = sdata_q;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W+1:2];
          size_d  = req_size_n;
          off_d   = req_off_n;
          sgn_d   = req_signed;
          sdata_d = req_wdata[15:0];
          rdata_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
          if (req_bad)                   state_d = S_ERR;
          else
`endif
          if (!req_we)                   state_d = S_LOAD;
          else if (req_size_n == 2'b10) begin
            wdata_d = req_wdata;
            state_d = S_WRITE;
          end else                       state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = extract(ram_rdata, size_q, off_q, sgn_q);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wdata_d = merge(ram_rdata, size_q, off_q, sdata_q);
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
`ifdef LSU_ALIGN_CHECK_EN
      S_ERR: begin
        rdata_d = '0;
        state_d = S_RESP;
      end
`endif
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sdata_q <= sdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= 1'b0;
    else if (state_q == S_IDLE && req_valid) err_q <= 1'b0;
    else if (state_q == S_ERR)               err_q <= 1'b1;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: ram_we decodes the async-reset state register, so it drops at once when rst_n falls.
  assign ram_we    = (state_q == S_WRITE);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small behavioural data RAM.
// Expectations for misaligned requests follow LSU_ALIGN_CHECK_EN.
module tb_load_store_unit;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:15];
  int          wr_cnt = 0;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[3:0]];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[3:0]] <= ram_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ram_addr;
      wr_data <= ram_wdata;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [17:0] addr, input logic [31:0] wd, output int lat);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_before_issue: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_tests++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    n_tests++; if (ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram_wdata: got %h want 0", ram_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store();
    int lat, w0;
    w0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 18'h10, 32'hDEADBEEF, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL wstore_latency: got %0d want 2", lat); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wstore_err: got %b want 0", rsp_err); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wstore_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL wstore_we_cycles: got %0d want 1", wr_cnt - w0); end
    n_tests++; if (wr_addr !== 16'h0004) begin n_fail++; $display("FAIL wstore_addr: got %h want 0004", wr_addr); end
    n_tests++; if (wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore_data: got %h want deadbeef", wr_data); end
    consume();
  endtask

  task automatic test_subword_store();
    int lat, w0;
    issue(1'b1, 2'b10, 1'b0, 18'h10, 32'h11223344, lat);
    consume();
    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 18'h12, 32'h000000AA, lat);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL bstore_latency: got %0d want 3", lat); end
    n_tests++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL bstore_we_cycles: got %0d want 1", wr_cnt - w0); end
    n_tests++; if (wr_addr !== 16'h0004) begin n_fail++; $display("FAIL bstore_addr: got %h want 0004", wr_addr); end
    n_tests++; if (wr_data !== 32'h11AA3344) begin n_fail++; $display("FAIL bstore_data: got %h want 11aa3344", wr_data); end
    consume();
    issue(1'b1, 2'b01, 1'b0, 18'h12, 32'h1234BEEF, lat);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL hstore_latency: got %0d want 3", lat); end
    n_tests++; if (wr_data !== 32'hBEEF3344) begin n_fail++; $display("FAIL hstore_data: got %h want beef3344", wr_data); end
    consume();
    issue(1'b0, 2'b10, 1'b0, 18'h10, 32'h0, lat);
    n_tests++; if (rsp_rdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL hstore_readback: got %h want beef3344", rsp_rdata); end
    consume();
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz  [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        sg  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [17:0] ad  [7] = '{18'h23, 18'h23, 18'h21, 18'h22, 18'h22, 18'h20, 18'h20};
    logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFFFFFF,
                             32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    int lat;
    issue(1'b1, 2'b10, 1'b0, 18'h20, 32'h80FF7F01, lat);
    consume();
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'h0, lat);
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
      n_tests++; if (rsp_rdata !== exp[i]) begin n_fail++; $display("FAIL load%0d_data: got %h want %h", i, rsp_rdata, exp[i]); end
      consume();
    end
  endtask

  task automatic test_misaligned();
    int lat, w0;
    logic        e_err;
    logic [31:0] e_half, e_rsv;
`ifdef LSU_ALIGN_CHECK_EN
    e_err = 1'b1; e_half = 32'h0; e_rsv = 32'h0;
`else
    e_err = 1'b0; e_half = 32'h00003344; e_rsv = 32'h80FF7F01;
`endif
    w0 = wr_cnt;
    issue(1'b0, 2'b01, 1'b0, 18'h11, 32'h0, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL misal_latency: got %0d want 2", lat); end
    n_tests++; if (rsp_err !== e_err) begin n_fail++; $display("FAIL misal_err: got %b want %b", rsp_err, e_err); end
    n_tests++; if (rsp_rdata !== e_half) begin n_fail++; $display("FAIL misal_rdata: got %h want %h", rsp_rdata, e_half); end
    consume();
    issue(1'b0, 2'b11, 1'b0, 18'h20, 32'h0, lat);
    n_tests++; if (rsp_err !== e_err) begin n_fail++; $display("FAIL rsvsize_err: got %b want %b", rsp_err, e_err); end
    n_tests++; if (rsp_rdata !== e_rsv) begin n_fail++; $display("FAIL rsvsize_rdata: got %h want %h", rsp_rdata, e_rsv); end
    consume();
    n_tests++; if (wr_cnt != w0) begin n_fail++; $display("FAIL misal_no_write: got %0d writes want 0", wr_cnt - w0); end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b0, 2'b00, 1'b1, 18'h23, 32'h0, lat);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 18'h10;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_valid: got %b want 1", i, rsp_valid); end
      n_tests++; if (rsp_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL bp%0d_rdata: got %h want ffffff80", i, rsp_rdata); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_req_ready: got %b want 0", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", rsp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
    n_tests++; if (rsp_rdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL bp_next_rdata: got %h want beef3344", rsp_rdata); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, w0;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'h12; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rsp_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_ram_we: got %b want 0", ram_we); end
    n_tests++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL rstmid_ram_addr: got %h want 0", ram_addr); end
    n_tests++; if (ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_ram_wdata: got %h want 0", ram_wdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (wr_cnt != w0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt - w0); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %b want 0", rsp_valid); end
    issue(1'b0, 2'b10, 1'b0, 18'h10, 32'h0, lat);
    n_tests++; if (rsp_rdata !== 32'hBEEF3344) begin n_fail++; $display("FAIL rstmid_mem_kept: got %h want beef3344", rsp_rdata); end
    consume();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_word_store();
    test_subword_store();
    test_load_ext();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
